// File: rtl/bias_ctrl.sv
// bias_ctrl: fetches one row of N bias scalars from the unified buffer on a
// start command, holds them on the bias columns, then gates the systolic
// array's per-column valids into the bias columns until every column has
// accepted num_rows rows. A one-cycle done pulse marks completion.
//
// Ports
//   clk, rst            clock / asynchronous active-low reset
//   start               command pulse, honoured only in IDLE
//   bias_base_addr      bias row address, latched on accepted start
//   num_rows            rows per column, latched on accepted start
//   ub_rd_req/addr      unified buffer read request (held until ack)
//   ub_rd_ack/data      buffer accept; data valid in the ack cycle
//   bias_scalar_out     held bias scalars, column i in slice i (signed 16b)
//   sys_valid_in        per-column valid from the systolic array
//   bias_valid_out      gated valid to the bias columns (combinational)
//   busy, done          status; done is a one-cycle pulse
//   overrun_err         sticky: a valid arrived that could not be accepted

// Per-column row counter: accepts valids while running and not yet full.
module bias_lane #(
  parameter int ROWS_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_run,
  input  logic              i_vld,
  input  logic [ROWS_W-1:0] i_rows,
  output logic              o_acc,
  output logic              o_done_nxt
);
  logic [ROWS_W-1:0] r_cnt;
  logic              r_done;
  logic [ROWS_W-1:0] w_cnt_inc;
  logic              w_last;

  assign o_acc      = i_run & i_vld & ~r_done;
  assign w_cnt_inc  = r_cnt + ROWS_W'(1);
  assign w_last     = o_acc && (w_cnt_inc == i_rows);
  // Lookahead so the controller can leave RUN in the cycle the last row lands.
  assign o_done_nxt = r_done | w_last;

  // Counting halts once the flag is set, so the counter never wraps.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_clr) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (o_acc) begin
      r_cnt <= w_cnt_inc;
      if (w_last) r_done <= 1'b1;
    end
  end
endmodule

module bias_ctrl #(
  parameter int N      = 2,
  parameter int ADDR_W = 16,
  parameter int ROWS_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     bias_base_addr,
  input  logic [ROWS_W-1:0]     num_rows,
  output logic                  ub_rd_req,
  output logic [ADDR_W-1:0]     ub_rd_addr,
  input  logic                  ub_rd_ack,
  input  logic [N-1:0][15:0]    ub_rd_data,
  output logic [N-1:0][15:0]    bias_scalar_out,
  input  logic [N-1:0]          sys_valid_in,
  output logic [N-1:0]          bias_valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  overrun_err
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_RUN, S_DONE} state_t;

  state_t            r_state;
  logic [ROWS_W-1:0] r_rows;
  logic              w_clr;
  logic              w_run;
  logic [N-1:0]      w_acc;
  logic [N-1:0]      w_done_nxt;
  logic [N-1:0]      w_rej;

  assign w_clr = (r_state == S_IDLE) && start;
  assign w_run = (r_state == S_RUN);

  bias_lane #(.ROWS_W(ROWS_W)) u_lane [N-1:0] (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_clr),
    .i_run      (w_run),
    .i_vld      (sys_valid_in),
    .i_rows     (r_rows),
    .o_acc      (w_acc),
    .o_done_nxt (w_done_nxt)
  );

  assign bias_valid_out = w_acc;
  // Anything offered but not forwarded is an overrun, in any state.
  assign w_rej = sys_valid_in & ~w_acc;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= S_IDLE;
      r_rows          <= '0;
      ub_rd_req       <= 1'b0;
      ub_rd_addr      <= '0;
      bias_scalar_out <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      overrun_err     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (|w_rej) overrun_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_rows      <= num_rows;
            ub_rd_addr  <= bias_base_addr;
            ub_rd_req   <= 1'b1;
            busy        <= 1'b1;
            // Start clears the sticky flag; a same-cycle reject still counts.
            overrun_err <= |w_rej;
            r_state     <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (ub_rd_ack) begin
            bias_scalar_out <= ub_rd_data;
            ub_rd_req       <= 1'b0;
            if (r_rows == '0) begin
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (&w_done_nxt) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bias_ctrl.sv
// Scoreboard bench for bias_ctrl (N=2): each transaction's expected fetch
// address, bias data, per-column forwarded row count, done cycle and overrun
// state are pushed at start; a negedge monitor checks them as the DUT responds.
module tb_bias_ctrl;
  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [15:0]       bias_base_addr;
  logic [15:0]       num_rows;
  logic              ub_rd_req;
  logic [15:0]       ub_rd_addr;
  logic              ub_rd_ack;
  logic [1:0][15:0]  ub_rd_data;
  logic [1:0][15:0]  bias_scalar_out;
  logic [1:0]        sys_valid_in;
  logic [1:0]        bias_valid_out;
  logic              busy;
  logic              done;
  logic              overrun_err;

  bias_ctrl #(.N(2), .ADDR_W(16), .ROWS_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .bias_base_addr(bias_base_addr),
    .num_rows(num_rows), .ub_rd_req(ub_rd_req), .ub_rd_addr(ub_rd_addr),
    .ub_rd_ack(ub_rd_ack), .ub_rd_data(ub_rd_data),
    .bias_scalar_out(bias_scalar_out), .sys_valid_in(sys_valid_in),
    .bias_valid_out(bias_valid_out), .busy(busy), .done(done),
    .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0]      addr;
    logic [1:0][15:0] dat;
    int               rows;
    int               dcyc;
    bit               ovr;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  // ---------------- monitor ----------------
  int               cnt0, cnt1;
  bit               post;
  bit               post_ovr;
  logic [1:0][15:0] post_dat;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      cnt0 = 0; cnt1 = 0; post = 0;
    end else begin
      cnt0 += int'(bias_valid_out[0]);
      cnt1 += int'(bias_valid_out[1]);
      if (ub_rd_req && q.size() != 0) chk("rd_addr", ub_rd_addr, q[0].addr);
      if (post) begin
        chk("done_width", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("ovr_held", overrun_err, post_ovr);
        chk("bias_held", bias_scalar_out, post_dat);
        post = 0;
      end
      if (done) begin
        chk("done_expected", q.size() != 0, 1'b1);
        if (q.size() != 0) begin
          e = q.pop_front();
          chk("bias_data", bias_scalar_out, e.dat);
          chk("rows_col0", cnt0, e.rows);
          chk("rows_col1", cnt1, e.rows);
          chk("done_cycle", cyc, e.dcyc);
          chk("overrun", overrun_err, e.ovr);
          chk("busy_in_done", busy, 1'b1);
          post = 1; post_ovr = e.ovr; post_dat = e.dat;
        end
        cnt0 = 0; cnt1 = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_txn(input logic [15:0] base, input int rows,
                         input logic [1:0][15:0] dat, input int dly,
                         input int skew, input bit gaps, input bit extra,
                         input bit fvld, input bit istart);
    logic [1:0] vv [0:31];
    int   seen [2];
    int   o, last0, last1, maxlast, a, n;
    exp_t e;
    foreach (vv[i]) vv[i] = 2'b00;
    last0 = 0; last1 = 0;
    // Valid pattern per column, offsets relative to the first RUN cycle.
    o = 0;
    for (int k = 0; k < rows; k++) begin
      vv[o][0] = 1'b1; last0 = o;
      o += 1 + (gaps ? int'($urandom_range(0, 1)) : 0);
    end
    o = skew;
    for (int k = 0; k < rows; k++) begin
      vv[o][1] = 1'b1; last1 = o;
      o += 1 + (gaps ? int'($urandom_range(0, 1)) : 0);
    end
    maxlast = (last0 > last1) ? last0 : last1;
    if (extra && rows > 0 && last0 + 1 <= maxlast) vv[last0 + 1][0] = 1'b1;
    // Reference: the first `rows` valids per column are taken; any further
    // valid, or any valid offered during the fetch, is an overrun.
    e.ovr = fvld;
    seen[0] = 0; seen[1] = 0;
    if (rows > 0)
      for (int t = 0; t <= maxlast; t++)
        for (int c = 0; c < 2; c++)
          if (vv[t][c]) begin
            seen[c]++;
            if (seen[c] > rows) e.ovr = 1'b1;
          end
    a       = cyc + 1 + dly;
    e.addr  = base;
    e.dat   = dat;
    e.rows  = rows;
    e.dcyc  = (rows == 0) ? a + 1 : a + 2 + maxlast;
    start = 1'b1; bias_base_addr = base; num_rows = 16'(rows);
    q.push_back(e);
    step();
    start = 1'b0; bias_base_addr = 16'($urandom); num_rows = 16'($urandom);
    for (int k = 0; k <= dly; k++) begin
      sys_valid_in = (k == 0 && fvld) ? 2'($urandom_range(1, 3)) : 2'b00;
      start        = istart && (k == ((dly > 0) ? 1 : 0));
      ub_rd_ack    = (k == dly);
      ub_rd_data   = (k == dly) ? dat : 32'($urandom);
      step();
    end
    start = 1'b0; ub_rd_ack = 1'b0; sys_valid_in = 2'b00;
    ub_rd_data = 32'($urandom);
    if (rows > 0)
      for (int t = 0; t <= maxlast; t++) begin
        sys_valid_in = vv[t];
        start        = istart && (t == 0);
        step();
      end
    start = 1'b0; sys_valid_in = 2'b00;
    n = 0;
    while (busy && n < 100) begin
      ub_rd_ack  = 1'($urandom);   // no request outstanding: must be ignored
      ub_rd_data = 32'($urandom);
      step();
      n++;
    end
    ub_rd_ack = 1'b0;
    if (n >= 100) chk("timeout_busy", 1'b1, 1'b0);
  endtask

  initial begin
    exp_t e;
    rst = 1'b0; start = 1'b0; bias_base_addr = '0; num_rows = '0;
    ub_rd_ack = 1'b0; ub_rd_data = '0; sys_valid_in = 2'b00;
    #2;
    chk("rst_req",  ub_rd_req, 1'b0);
    chk("rst_addr", ub_rd_addr, 16'h0);
    chk("rst_bias", bias_scalar_out, 32'h0);
    chk("rst_busy_done_ovr", {busy, done, overrun_err}, 3'b000);
    repeat (3) @(posedge clk);
    #1; rst = 1'b1;
    step();

    // basic, skew, overrun, clean (overrun cleared), stall+ignore, zero rows
    run_txn(16'h0010, 3, {16'hFFFE, 16'h0005}, 2, 0, 0, 0, 0, 0);
    run_txn(16'h0020, 4, {16'h1234, 16'h8001}, 1, 2, 0, 0, 0, 0);
    run_txn(16'h0030, 4, {16'h7FFF, 16'h0001}, 1, 2, 0, 1, 1, 0);
    run_txn(16'h0040, 2, {16'hAAAA, 16'h5555}, 0, 0, 0, 0, 0, 0);
    run_txn(16'h0050, 3, {16'h0F0F, 16'hF0F0}, 10, 1, 0, 0, 0, 1);
    run_txn(16'h0060, 0, {16'h4321, 16'h8765}, 1, 0, 0, 0, 1, 0);

    // reset in the middle of RUN after one accepted row
    start = 1'b1; bias_base_addr = 16'h0070; num_rows = 16'd3;
    e.addr = 16'h0070; e.dat = '0; e.rows = 3; e.dcyc = -1; e.ovr = 0;
    q.push_back(e);
    step();
    start = 1'b0; ub_rd_ack = 1'b1; ub_rd_data = {16'h1111, 16'h2222};
    step();
    ub_rd_ack = 1'b0; sys_valid_in = 2'b11;
    step();
    #2; rst = 1'b0; #1;
    chk("midrst_req",  ub_rd_req, 1'b0);
    chk("midrst_addr", ub_rd_addr, 16'h0);
    chk("midrst_bias", bias_scalar_out, 32'h0);
    chk("midrst_vld",  bias_valid_out, 2'b00);
    chk("midrst_busy_done_ovr", {busy, done, overrun_err}, 3'b000);
    q.delete();
    sys_valid_in = 2'b00;
    step(); step();
    rst = 1'b1;
    step();
    run_txn(16'h0080, 3, {16'hFFFF, 16'h0003}, 1, 0, 0, 0, 0, 0);

    // randomized transactions
    for (int i = 0; i < 25; i++)
      run_txn(16'($urandom), int'($urandom_range(0, 6)), 32'($urandom),
              int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    step(); step();
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
